// File: rtl/gpio_in_cond.sv
// gpio_in_cond
//   Input conditioning for GPIO pads: two-flop synchronizer, prescaled
//   three-sample glitch filter, edge pulse generation, sticky edge status
//   and a masked level interrupt.
//
// Parameters
//   DIV    sample-tick period in sys_clk cycles (1..65535)
//   WIDTH  number of GPIO bits
//
// Ports
//   sys_clk      single clock, rising edge
//   rst_n        synchronous active-low reset
//   gpio_pad     raw asynchronous pad inputs
//   irq_mask     per-bit interrupt enable (1 = enabled)
//   irq_clr      per-bit write-1-to-clear for edge_status, sampled every cycle
//   gpio_filt    synchronized, debounced pad value
//   rise_pulse   one-cycle pulse on a filtered 0->1 transition
//   fall_pulse   one-cycle pulse on a filtered 1->0 transition
//   edge_status  sticky edge-seen flags
//   irq          OR of (edge_status & irq_mask)
module gpio_in_cond #(
    parameter int unsigned DIV   = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_pad,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpio_filt,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] edge_status,
    output logic             irq
);

    localparam logic [15:0] CNT_MAX = 16'(DIV - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] hist0;
    logic [WIDTH-1:0] hist1;
    logic [15:0]      cnt;
    logic             tick;
    logic [WIDTH-1:0] chg;

    assign tick = (cnt == CNT_MAX);

    // A bit changes only on a tick where the two stored samples and the
    // current synchronized value agree and differ from the filtered value.
    always_comb begin
        chg = '0;
        if (tick) begin
            chg = ~(hist1 ^ hist0) & ~(hist0 ^ sync2) & (sync2 ^ gpio_filt);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            hist0       <= '0;
            hist1       <= '0;
            cnt         <= '0;
            gpio_filt   <= '0;
            rise_pulse  <= '0;
            fall_pulse  <= '0;
            edge_status <= '0;
        end else begin
            sync1 <= gpio_pad;
            sync2 <= sync1;
            cnt   <= tick ? '0 : cnt + 16'd1;
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
            end
            gpio_filt  <= gpio_filt ^ chg;
            rise_pulse <= chg & sync2;
            fall_pulse <= chg & ~sync2;
            // Set from last cycle's pulses wins over a same-cycle clear.
            edge_status <= (edge_status & ~irq_clr) | rise_pulse | fall_pulse;
        end
    end

    assign irq = |(edge_status & irq_mask);

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond
//   Two DUT instances (DIV=4 and DIV=1). A reference model updated once per
//   clock edge pushes the expected outputs into a queue; a monitor on the
//   falling edge pops and compares them against the DUT outputs.
module tb_gpio_in_cond;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_v [2];
    logic [31:0] pad_v  [2];
    logic [31:0] mask_v [2];
    logic [31:0] clr_v  [2];
    logic        nx_rstn[2];
    logic [31:0] nx_pad [2];
    logic [31:0] nx_mask[2];
    logic [31:0] nx_clr [2];

    logic [31:0] filt_o[2];
    logic [31:0] rise_o[2];
    logic [31:0] fall_o[2];
    logic [31:0] es_o  [2];
    logic        irq_o [2];

    gpio_in_cond #(.DIV(DIV_A), .WIDTH(32)) u_dut_a (
        .sys_clk(clk), .rst_n(rstn_v[0]), .gpio_pad(pad_v[0]),
        .irq_mask(mask_v[0]), .irq_clr(clr_v[0]), .gpio_filt(filt_o[0]),
        .rise_pulse(rise_o[0]), .fall_pulse(fall_o[0]),
        .edge_status(es_o[0]), .irq(irq_o[0])
    );

    gpio_in_cond #(.DIV(DIV_B), .WIDTH(32)) u_dut_b (
        .sys_clk(clk), .rst_n(rstn_v[1]), .gpio_pad(pad_v[1]),
        .irq_mask(mask_v[1]), .irq_clr(clr_v[1]), .gpio_filt(filt_o[1]),
        .rise_pulse(rise_o[1]), .fall_pulse(fall_o[1]),
        .edge_status(es_o[1]), .irq(irq_o[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d actual=%h required=%h time=%0t",
                         name, d, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          n_edges[2];     // edges since reset release
    logic [31:0] m_p1[2];        // pad seen one edge ago
    logic [31:0] m_p2[2];        // pad seen two edges ago (synchronized view)
    logic [31:0] m_filt[2];
    logic [31:0] m_rise[2];
    logic [31:0] m_fall[2];
    logic [31:0] m_es[2];
    logic [31:0] samp_a[$];      // recent tick samples, oldest first
    logic [31:0] samp_b[$];

    task automatic model_edge(input int d);
        logic [31:0] s_old, s_mid, s_now, chg;
        int dv;
        dv = (d == 0) ? DIV_A : DIV_B;
        if (!rstn_v[d]) begin
            n_edges[d] = 0;
            m_p1[d] = '0; m_p2[d] = '0;
            m_filt[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_es[d] = '0;
            if (d == 0) samp_a = '{32'h0, 32'h0};
            else        samp_b = '{32'h0, 32'h0};
        end else begin
            m_es[d] = (m_es[d] & ~clr_v[d]) | m_rise[d] | m_fall[d];
            m_rise[d] = '0;
            m_fall[d] = '0;
            if ((n_edges[d] % dv) == dv - 1) begin
                s_now = m_p2[d];
                if (d == 0) begin
                    s_old = samp_a.pop_front(); s_mid = samp_a[0]; samp_a.push_back(s_now);
                end else begin
                    s_old = samp_b.pop_front(); s_mid = samp_b[0]; samp_b.push_back(s_now);
                end
                chg = '0;
                for (int i = 0; i < 32; i++)
                    if (s_old[i] == s_mid[i] && s_mid[i] == s_now[i] && s_now[i] != m_filt[d][i])
                        chg[i] = 1'b1;
                m_rise[d] = chg & s_now;
                m_fall[d] = chg & ~s_now;
                m_filt[d] = m_filt[d] ^ chg;
            end
            n_edges[d]++;
            m_p2[d] = m_p1[d];
            m_p1[d] = pad_v[d];
        end
    endtask

    typedef struct {
        int          d;
        logic [31:0] filt;
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] es;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];

    // One clock: update the model for the edge just taken, apply the next
    // inputs, and queue the expected outputs for the monitor.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #2;
        model_edge(0);
        model_edge(1);
        for (int d = 0; d < 2; d++) begin
            rstn_v[d] = nx_rstn[d];
            pad_v[d]  = nx_pad[d];
            mask_v[d] = nx_mask[d];
            clr_v[d]  = nx_clr[d];
            e.d = d; e.filt = m_filt[d]; e.rise = m_rise[d]; e.fall = m_fall[d];
            e.es = m_es[d]; e.irq = |(m_es[d] & mask_v[d]);
            exp_q.push_back(e);
        end
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gpio_filt",   e.d, filt_o[e.d], e.filt);
            chk("rise_pulse",  e.d, rise_o[e.d], e.rise);
            chk("fall_pulse",  e.d, fall_o[e.d], e.fall);
            chk("edge_status", e.d, es_o[e.d],   e.es);
            chk("irq",         e.d, {31'b0, irq_o[e.d]}, {31'b0, e.irq});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rise_cnt;
        int pulse_cnt;
        int found;
        for (int d = 0; d < 2; d++) begin
            rstn_v[d] = 1'b0; pad_v[d] = '0; mask_v[d] = '0; clr_v[d] = '0;
            nx_rstn[d] = 1'b0; nx_pad[d] = '0; nx_mask[d] = '0; nx_clr[d] = '0;
        end
        nx_mask[0] = '1;
        repeat (3) step();
        chk("reset_filt", 0, filt_o[0], 32'h0);
        chk("reset_es",   1, es_o[1],   32'h0);
        chk("reset_irq",  0, {31'b0, irq_o[0]}, 32'h0);

        // bit 0 held high on DIV=4; upper half high on DIV=1 with mask 0
        nx_rstn[0] = 1'b1; nx_pad[0] = 32'h0000_0001;
        nx_rstn[1] = 1'b1; nx_pad[1] = 32'hFFFF_0000;
        rise_cnt = 0;
        repeat (14) begin
            step();
            if (rise_o[0] != 32'h0) rise_cnt++;
        end
        chk("rise_latency_filt", 0, filt_o[0], 32'h0000_0001);
        chk("rise_once",         0, rise_cnt,  1);
        chk("rise_status",       0, es_o[0],   32'h0000_0001);
        chk("rise_irq",          0, {31'b0, irq_o[0]}, 32'h1);
        chk("div1_filt",         1, filt_o[1], 32'hFFFF_0000);
        chk("div1_status",       1, es_o[1],   32'hFFFF_0000);
        chk("div1_masked_irq",   1, {31'b0, irq_o[1]}, 32'h0);
        nx_mask[1] = 32'h0001_0000;
        step();
        chk("div1_mask_irq", 1, {31'b0, irq_o[1]}, 32'h1);
        chk("div1_mask_es",  1, es_o[1], 32'hFFFF_0000);

        // short pulse on bit 4 must be filtered away
        nx_pad[0] = 32'h0000_0011;
        pulse_cnt = 0;
        repeat (4) begin
            step();
            if ((rise_o[0] | fall_o[0]) != 32'h0) pulse_cnt++;
        end
        nx_pad[0] = 32'h0000_0001;
        repeat (20) begin
            step();
            if ((rise_o[0] | fall_o[0]) != 32'h0) pulse_cnt++;
        end
        chk("glitch_filt",   0, filt_o[0], 32'h0000_0001);
        chk("glitch_pulses", 0, pulse_cnt, 0);
        chk("glitch_status", 0, es_o[0],   32'h0000_0001);

        // falling edge, then clear coincident with set and one cycle later
        nx_clr[0] = 32'h1; step();
        nx_clr[0] = 32'h0; step();
        chk("pre_clear", 0, es_o[0], 32'h0);
        nx_pad[0] = 32'h0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (m_fall[0] == 32'h1) found = 1;
        end
        chk("fall_seen", 0, found, 1);
        chk("fall_pulse_dir", 0, fall_o[0], 32'h1);
        nx_clr[0] = 32'h1;
        step();
        chk("set_beats_clr", 0, es_o[0], 32'h1);
        step();
        chk("clr_after", 0, es_o[0], 32'h0);
        chk("clr_irq",   0, {31'b0, irq_o[0]}, 32'h0);
        nx_clr[0] = 32'h0;

        // reset in the middle of debouncing 0xF0
        nx_pad[0] = 32'h0000_00F0;
        repeat (2) step();
        nx_rstn[0] = 1'b0;
        pulse_cnt = 0;
        repeat (2) begin
            step();
            if ((rise_o[0] | fall_o[0] | filt_o[0] | es_o[0]) != 32'h0) pulse_cnt++;
        end
        step();
        if ((rise_o[0] | fall_o[0] | filt_o[0] | es_o[0]) != 32'h0) pulse_cnt++;
        chk("reset_quiet", 0, pulse_cnt, 0);
        nx_rstn[0] = 1'b1;
        found = 0;
        repeat (20) begin
            step();
            if (rise_o[0] == 32'h0000_00F0) found++;
        end
        chk("post_reset_rise", 0, found, 1);

        // randomized traffic on both instances
        for (int k = 0; k < 3000; k++) begin
            nx_pad[0] = nx_pad[0] ^ ($urandom & $urandom & $urandom & $urandom);
            nx_pad[1] = nx_pad[1] ^ ($urandom & $urandom);
            for (int d = 0; d < 2; d++) begin
                nx_clr[d]  = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 49) == 0) nx_mask[d] = $urandom;
                nx_rstn[d] = ($urandom_range(0, 299) != 0);
            end
            step();
        end
        nx_rstn[0] = 1'b1; nx_rstn[1] = 1'b1;
        repeat (2) step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameter DIV, default 16, meaning the sample-tick period in sys_clk cycles (legal range 1..65535).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the number of GPIO bits.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port gpio_pad, input, WIDTH bits: raw asynchronous pad inputs.
REQ-006 SHALL have port irq_mask, input, WIDTH bits: per-bit interrupt enable (1 = enabled).
REQ-007 SHALL have port irq_clr, input, WIDTH bits: per-bit write-1-to-clear strobe for edge_status, level-sampled each cycle.
REQ-008 SHALL have port gpio_filt, output, WIDTH bits: synchronized, debounced value that drives gpio_ctrl_top gpio_in.
REQ-009 SHALL have port rise_pulse, output, WIDTH bits: one-cycle pulse per bit on a filtered 0->1 transition.
REQ-010 SHALL have port fall_pulse, output, WIDTH bits: one-cycle pulse per bit on a filtered 1->0 transition.
REQ-011 SHALL have port edge_status, output, WIDTH bits: sticky per-bit edge-seen flags.
REQ-012 SHALL have port irq, output, 1 bit: interrupt request, level.

Function
REQ-013 SHALL pass gpio_pad through a two-flop synchronizer per bit (sync1, sync2); only sync2 is used downstream.
REQ-014 SHALL run a prescaler counter: 0 to DIV-1, then wraps to 0; tick = (count == DIV-1); DIV=1 gives tick every cycle.
REQ-015 SHALL keep, per bit, a 2-deep sample history hist[1:0], shifted only on tick cycles: hist <= {hist[0], sync2}.
REQ-016 SHALL, on a tick cycle, set gpio_filt[i] <= sync2[i] when hist[1][i], hist[0][i] and sync2[i] are all equal and differ from gpio_filt[i]; otherwise gpio_filt[i] holds.
REQ-017 SHALL produce rise_pulse[i] / fall_pulse[i] registered in the same edge as the gpio_filt[i] update, high for exactly one cycle; both are never high together for one bit.
REQ-018 SHALL set edge_status[i] the cycle after rise_pulse[i] or fall_pulse[i] is high (sticky) and clear it when irq_clr[i]=1; simultaneous set and clear SHALL leave it set.
REQ-019 SHALL drive irq = OR over i of (edge_status[i] AND irq_mask[i]), combinational from registered status; mask changes affect irq in the same cycle and never alter edge_status.
REQ-020 SHALL reject any pad pulse shorter than 3 consecutive equal tick samples (glitch filter); worst-case latency pad->gpio_filt = 2 + 3*DIV cycles.
REQ-021 SHALL treat all bits independently; multiple bits may pulse in the same cycle.

Reset
REQ-022 SHALL, while rst_n=0 at a sys_clk edge, clear sync1, sync2, hist, prescaler count, gpio_filt, rise_pulse, fall_pulse and edge_status to 0; irq is therefore 0.
REQ-023 SHALL, on reset asserted mid-debounce or mid-pulse, abort all in-progress filtering with no pulse emitted; the prescaler restarts from 0 on release.
REQ-024 SHALL NOT recognize pads held high through reset as edges until they reach 3 agreeing ticks after release (a 0->1 rise is then reported).

Verification
REQ-025 DIV=4, mask=all-1: after reset, pad=0x00000001 held -> gpio_filt=0x00000001 within 14 cycles, rise_pulse=0x00000001 for exactly 1 cycle, edge_status=0x00000001, irq=1.
REQ-026 DIV=4: pad bit 4 high for 4 cycles then low -> gpio_filt, rise_pulse and fall_pulse stay 0x00000000; edge_status unchanged.
REQ-027 DIV=4: with gpio_filt=0x00000001, pad=0x0 held -> fall_pulse=0x00000001 for 1 cycle; irq_clr=0x00000001 asserted the cycle edge_status would set -> edge_status stays 0x00000001; irq_clr 1 cycle later -> edge_status=0x0, irq=0.
REQ-028 DIV=1, mask=0x0: pad=0xFFFF0000 -> gpio_filt=0xFFFF0000 after 5 cycles, edge_status=0xFFFF0000, irq=0; then mask=0x00010000 -> irq=1 the same cycle.
REQ-029 DIV=4: pad=0x000000F0, rst_n=0 for 2 cycles asserted 2 cycles after the pad change -> all outputs 0 during reset, no pulse during reset, rise_pulse=0x000000F0 later once 3 agreeing ticks follow release.
